// File: rtl/uart_rx_ctrl.sv
// Control layer around the bit-level UART receiver: mode decode with safe
// reconfiguration, FWFT receive FIFO, RTS hysteresis, error stats and idle timeout.
module uart_rx_ctrl #(
    parameter int          DEPTH   = 8,
    parameter int          RTS_HI  = 6,
    parameter int          RTS_LO  = 2,
    parameter logic [15:0] TIMEOUT = 16'd20000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cfg_wr,
    input  logic [7:0]  i_cfg_data,
    output logic        o_rx_en,
    output logic [15:0] o_baud_div,
    output logic        o_stop2,
    output logic        o_par_en,
    output logic        o_par_odd,
    input  logic        i_rx_busy,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_par_err,
    input  logic        i_rx_stop_err,
    output logic        o_out_valid,
    output logic [7:0]  o_out_data,
    output logic [1:0]  o_out_err,
    input  logic        i_out_ready,
    output logic        o_rts,
    output logic [4:0]  o_level,
    output logic        o_overrun,
    output logic [7:0]  o_err_count,
    output logic        o_timeout,
    output logic [1:0]  o_state
);

    // Handshake: the head entry transfers on every rising edge where
    // o_out_valid and i_out_ready are both 1; o_out_valid never depends on i_out_ready.

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_APPLY    = 2'd3
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [7:0]     r_mode, r_pend, w_mode_nxt, w_pend_nxt;
    logic [9:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [4:0]     r_level;
    logic           r_rts;
    logic           r_overrun;
    logic [7:0]     r_err_count;
    logic [15:0]    r_idle;
    logic           w_full, w_pop, w_push_req, w_push, w_drop, w_err;

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_pend_nxt  = r_pend;
        case (r_state)
            ST_DISABLED: begin
                if (i_cfg_wr) begin
                    w_mode_nxt = i_cfg_data;
                    if (i_cfg_data[4]) w_state_nxt = ST_APPLY;
                end
            end
            ST_RUN: begin
                if (i_cfg_wr) begin
                    w_pend_nxt  = i_cfg_data;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // a write landing on the commit cycle still wins
                if (i_cfg_wr) w_pend_nxt = i_cfg_data;
                if (!i_rx_busy) begin
                    w_mode_nxt  = w_pend_nxt;
                    w_state_nxt = w_pend_nxt[4] ? ST_APPLY : ST_DISABLED;
                end
            end
            ST_APPLY:    w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_DISABLED;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_DISABLED;
            r_mode  <= 8'h00;
            r_pend  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_baud_div <= 16'd10416;
            o_stop2    <= 1'b1;
            o_par_en   <= 1'b0;
            o_par_odd  <= 1'b0;
        end else begin
            case (r_mode[7:6])
                2'b00:   o_baud_div <= 16'd10416;
                2'b01:   o_baud_div <= 16'd5208;
                2'b10:   o_baud_div <= 16'd2604;
                default: o_baud_div <= 16'd868;
            endcase
            o_stop2   <= ~r_mode[5];
            o_par_en  <= r_mode[0];
            o_par_odd <= r_mode[1];
        end
    end

    assign w_full     = (r_level == 5'(DEPTH));
    assign w_pop      = o_out_valid & i_out_ready;
    assign w_push_req = i_rx_valid & ((r_state == ST_RUN) | (r_state == ST_DRAIN));
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_err      = i_rx_par_err | i_rx_stop_err;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_rx_stop_err, i_rx_par_err, i_rx_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun   <= 1'b0;
            r_err_count <= 8'd0;
            r_rts       <= 1'b1;
            r_idle      <= 16'd0;
        end else begin
            if (i_cfg_wr)    r_overrun <= 1'b0;
            else if (w_drop) r_overrun <= 1'b1;
            if (i_cfg_wr)
                r_err_count <= 8'd0;
            else if (w_push_req && w_err && r_err_count != 8'hFF)
                r_err_count <= r_err_count + 8'd1;
            // hysteresis band between RTS_LO and RTS_HI holds the last value
            if (r_state != ST_RUN)             r_rts <= 1'b1;
            else if (r_level >= 5'(RTS_HI))    r_rts <= 1'b1;
            else if (r_level <= 5'(RTS_LO))    r_rts <= 1'b0;
            if (w_push || w_pop || r_level == 5'd0) r_idle <= 16'd0;
            else if (r_idle != 16'hFFFF)            r_idle <= r_idle + 16'd1;
        end
    end

    assign o_rx_en     = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign o_out_valid = (r_level != 5'd0);
    assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr][7:0] : 8'h00;
    assign o_out_err   = o_out_valid ? r_mem[r_rd_ptr][9:8] : 2'b00;
    assign o_rts       = r_rts | (r_state != ST_RUN);
    assign o_level     = r_level;
    assign o_overrun   = r_overrun;
    assign o_err_count = r_err_count;
    assign o_timeout   = (r_idle >= TIMEOUT) && o_out_valid;
    assign o_state     = r_state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed + randomized bench for uart_rx_ctrl against a queue-based
// behavioural model of the receive control layer.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int RTS_HI = 6;
    localparam int RTS_LO = 2;
    localparam int TMO = 20000;
    localparam int M_DIS = 0, M_RUN = 1, M_DRAIN = 2, M_APPLY = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [7:0]  cfg_data = 8'h00;
    logic        rx_busy = 1'b0, rx_valid = 1'b0, rx_par_err = 1'b0, rx_stop_err = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        out_ready = 1'b0;
    logic        rx_en, stop2, par_en, par_odd, out_valid, rts, overrun, timeout;
    logic [15:0] baud_div;
    logic [7:0]  out_data, err_count;
    logic [1:0]  out_err, state;
    logic [4:0]  level;

    uart_rx_ctrl #(.DEPTH(DEPTH), .RTS_HI(RTS_HI), .RTS_LO(RTS_LO), .TIMEOUT(16'd20000)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_wr(cfg_wr), .i_cfg_data(cfg_data),
        .o_rx_en(rx_en), .o_baud_div(baud_div), .o_stop2(stop2), .o_par_en(par_en),
        .o_par_odd(par_odd), .i_rx_busy(rx_busy), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .i_rx_par_err(rx_par_err), .i_rx_stop_err(rx_stop_err), .o_out_valid(out_valid),
        .o_out_data(out_data), .o_out_err(out_err), .i_out_ready(out_ready), .o_rts(rts),
        .o_level(level), .o_overrun(overrun), .o_err_count(err_count), .o_timeout(timeout),
        .o_state(state)
    );

    always #5 clk = ~clk;

    // behavioural model; FIFO is a queue of {stop_err, par_err, data}
    logic [9:0]  exp_q[$];
    int          m_state, m_idle;
    logic [7:0]  m_mode, m_pend, m_errc;
    logic [15:0] m_baud;
    logic        m_stop2, m_par_en, m_par_odd, m_ovr, m_rts;
    int          checks = 0, failures = 0;
    string       cur_step = "reset";

    function automatic logic [15:0] baud_of(input logic [1:0] sel);
        case (sel)
            2'd0: return 16'd10416;
            2'd1: return 16'd5208;
            2'd2: return 16'd2604;
            default: return 16'd868;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur_step, tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = exp_q.size();
        check("rx_en", 32'(rx_en), 32'(m_state == M_RUN || m_state == M_DRAIN));
        check("baud_div", 32'(baud_div), 32'(m_baud));
        check("stop2", 32'(stop2), 32'(m_stop2));
        check("par_en", 32'(par_en), 32'(m_par_en));
        check("par_odd", 32'(par_odd), 32'(m_par_odd));
        check("out_valid", 32'(out_valid), 32'(sz != 0));
        check("out_data", 32'(out_data), (sz != 0) ? 32'(exp_q[0][7:0]) : 32'd0);
        check("out_err", 32'(out_err), (sz != 0) ? 32'(exp_q[0][9:8]) : 32'd0);
        check("rts", 32'(rts), 32'(m_rts || m_state != M_RUN));
        check("level", 32'(level), 32'(sz));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("err_count", 32'(err_count), 32'(m_errc));
        check("timeout", 32'(timeout), 32'(m_idle >= TMO && sz != 0));
    endtask

    // advance one clock: predict from pre-edge inputs, then compare after the edge
    task automatic tick();
        int sz, ns;
        bit pop, preq, acc;
        logic [7:0] nm, np;
        sz = exp_q.size();
        pop = (sz != 0) && out_ready;
        preq = rx_valid && (m_state == M_RUN || m_state == M_DRAIN);
        acc = preq && (sz < DEPTH || pop);
        ns = m_state; nm = m_mode; np = m_pend;
        case (m_state)
            M_DIS: if (cfg_wr) begin nm = cfg_data; if (cfg_data[4]) ns = M_APPLY; end
            M_RUN: if (cfg_wr) begin np = cfg_data; ns = M_DRAIN; end
            M_DRAIN: begin
                if (cfg_wr) np = cfg_data;
                if (!rx_busy) begin nm = np; ns = np[4] ? M_APPLY : M_DIS; end
            end
            default: ns = M_RUN;
        endcase
        if (m_state != M_RUN) m_rts = 1'b1;
        else if (sz >= RTS_HI) m_rts = 1'b1;
        else if (sz <= RTS_LO) m_rts = 1'b0;
        if (acc || pop || sz == 0) m_idle = 0;
        else if (m_idle < 65535) m_idle++;
        m_baud = baud_of(m_mode[7:6]);
        m_stop2 = ~m_mode[5];
        m_par_en = m_mode[0];
        m_par_odd = m_mode[1];
        if (cfg_wr) m_errc = 8'd0;
        else if (preq && (rx_par_err || rx_stop_err) && m_errc != 8'd255) m_errc++;
        if (cfg_wr) m_ovr = 1'b0;
        else if (preq && !acc) m_ovr = 1'b1;
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({rx_stop_err, rx_par_err, rx_data});
        m_state = ns; m_mode = nm; m_pend = np;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send_cfg(input logic [7:0] d);
        cfg_wr = 1'b1; cfg_data = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pe, input logic se);
        rx_valid = 1'b1; rx_data = d; rx_par_err = pe; rx_stop_err = se;
        tick();
        rx_valid = 1'b0; rx_par_err = 1'b0; rx_stop_err = 1'b0;
    endtask

    task automatic send_rand();
        send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        m_state = M_DIS; m_mode = 8'h00; m_pend = 8'h00; m_baud = 16'd10416;
        m_stop2 = 1'b1; m_par_en = 1'b0; m_par_odd = 1'b0; m_errc = 8'd0;
        m_ovr = 1'b0; m_rts = 1'b1; m_idle = 0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_en", 32'(rx_en), 32'd0);
        check("rst_baud", 32'(baud_div), 32'd10416);
        check("rst_stop2", 32'(stop2), 32'd1);
        check("rst_rts", 32'(rts), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        compare_all();
        rst_n = 1'b1;
        tick();

        // enable with 8'h5D
        cur_step = "cfg_5d";
        send_cfg(8'h5D);
        check("apply_rx_en", 32'(rx_en), 32'd0);
        tick();
        check("run_rx_en", 32'(rx_en), 32'd1);
        check("run_baud", 32'(baud_div), 32'd5208);
        check("run_par_en", 32'(par_en), 32'd1);
        check("run_stop2", 32'(stop2), 32'd1);
        tick();
        check("run_rts", 32'(rts), 32'd0);

        // three bytes, ordered drain
        cur_step = "three_bytes";
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        check("lvl3", 32'(level), 32'd3);
        check("head_a5", 32'(out_data), 32'hA5);
        check("errc1", 32'(err_count), 32'd1);
        out_ready = 1'b1;
        tick();
        check("head_3c", 32'(out_data), 32'h3C);
        tick();
        check("head_ff", 32'(out_data), 32'hFF);
        check("err_ff", 32'(out_err), 32'd1);
        tick();
        out_ready = 1'b0;
        check("empty", 32'(out_valid), 32'd0);

        // RTS hysteresis
        cur_step = "rts";
        repeat (6) send_rand();
        tick();
        check("rts_hi", 32'(rts), 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        tick();
        check("rts_hold_l3", 32'(rts), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("rts_lo_l2", 32'(rts), 32'd0);

        // full FIFO: drop, then push with simultaneous pop
        cur_step = "full";
        repeat (6) send_rand();
        check("lvl8", 32'(level), 32'd8);
        send_rand();
        check("ovr_set", 32'(overrun), 32'd1);
        check("lvl8_drop", 32'(level), 32'd8);
        out_ready = 1'b1;
        send_rand();
        out_ready = 1'b0;
        check("lvl8_pp", 32'(level), 32'd8);

        // reconfigure while mid-frame
        cur_step = "reconfig";
        rx_busy = 1'b1;
        send_cfg(8'hD0);
        check("drain_rx_en", 32'(rx_en), 32'd1);
        check("drain_baud", 32'(baud_div), 32'd5208);
        check("ovr_clr", 32'(overrun), 32'd0);
        check("errc_clr", 32'(err_count), 32'd0);
        tick();
        check("drain_rts", 32'(rts), 32'd1);
        rx_busy = 1'b0;
        tick();
        check("apply2_rx_en", 32'(rx_en), 32'd0);
        send_rand();  // ignored in APPLY even though full
        check("apply_no_ovr", 32'(overrun), 32'd0);
        check("new_baud", 32'(baud_div), 32'd868);
        check("new_par_en", 32'(par_en), 32'd0);
        check("run2_rx_en", 32'(rx_en), 32'd1);

        // timeout boundary with one byte pending
        cur_step = "timeout";
        out_ready = 1'b1;
        repeat (7) tick();
        out_ready = 1'b0;
        check("lvl1", 32'(level), 32'd1);
        repeat (TMO - 1) tick();
        check("tmo_below", 32'(timeout), 32'd0);
        tick();
        check("tmo_set", 32'(timeout), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("tmo_clr", 32'(timeout), 32'd0);

        // disable
        cur_step = "disable";
        send_cfg(8'h00);
        tick();
        check("dis_rx_en", 32'(rx_en), 32'd0);
        check("dis_rts", 32'(rts), 32'd1);
        send_rand();
        check("dis_ignored", 32'(level), 32'd0);

        // randomized traffic with occasional reconfiguration
        cur_step = "random";
        send_cfg(8'h10 | 8'($urandom_range(0, 255)));
        for (int i = 0; i < 600; i++) begin
            rx_valid = ($urandom_range(0, 99) < 45);
            rx_data = 8'($urandom_range(0, 255));
            rx_par_err = ($urandom_range(0, 9) == 0);
            rx_stop_err = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 99) < 40);
            rx_busy = ($urandom_range(0, 3) == 0);
            cfg_wr = ($urandom_range(0, 49) == 0);
            cfg_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) != 0) cfg_data[4] = 1'b1;
            tick();
        end
        rx_valid = 1'b0; cfg_wr = 1'b0; out_ready = 1'b0; rx_busy = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
